// File: rtl/fifo_bus_pkg.sv
// -----------------------------------------------------------------------------
// fifo_bus_pkg
// Shared constants and types for the FIFO-target bus initiator.
//   - Register-bus addresses of the FIFO target (FIFO data, STAT, MEM).
//   - STAT register bit positions and the sticky-flag clear command.
//   - FSM state and access-intent enumerations.
// -----------------------------------------------------------------------------
package fifo_bus_pkg;

   localparam logic [1:0] ADDR_FIFO = 2'd0;
   localparam logic [1:0] ADDR_STAT = 2'd1;
   localparam logic [1:0] ADDR_MEM  = 2'd2;

   localparam int STAT_EMPTY = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_OVF   = 2;
   localparam int STAT_UNF   = 3;
   localparam int STAT_CLR   = 4;

   // Writing this to STAT clears the sticky overflow/underflow flags.
   localparam logic [7:0] CLR_CMD = 8'h10;

   typedef enum logic [2:0] {
      IDLE,
      POLL,
      WRITE,
      READ,
      RDW,
      OUT,
      CLEAR
   } state_t;

   typedef enum logic {
      WR,
      RD
   } intent_t;

endpackage

// File: rtl/fifo_bus_initiator.sv
// -----------------------------------------------------------------------------
// fifo_bus_initiator
// Drives the enable/addr/write/read/wdata register bus of a FIFO target.
// Bytes from the input stream are pushed into the target FIFO (addr 0); on a
// drain request the target FIFO is emptied onto the output stream. STAT
// (addr 1) is polled before every data access, and sticky overflow/underflow
// flags are cleared with a STAT write.
//
// Parameters
//   RD_LAT    cycles from a FIFO read strobe to valid bus_rdata (0 = same cycle)
//   POLL_MAX  consecutive full polls before err_timeout is raised
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid/in_data/in_ready     byte stream into the target FIFO
//   out_valid/out_data/out_ready  drained byte stream
//   drain_req/drain_done          drain request pulse / drain complete pulse
//   busy                          FSM active or drain pending
//   err_flag, err_timeout         sticky error indications (reset clears)
//   bus_enable/addr/write/read/wdata, bus_rdata, bus_resp   target bus
//
// Optional build macro FIFO_INIT_STATS_EN adds wr_count/rd_count outputs
// (bytes written to the target / bytes handed to the sink, 16-bit wrapping).
// -----------------------------------------------------------------------------
module fifo_bus_initiator
   import fifo_bus_pkg::*;
#(
   parameter int RD_LAT   = 1,
   parameter int POLL_MAX = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   input  logic       out_ready,
   input  logic       drain_req,
   output logic       drain_done,
   output logic       busy,
   output logic       err_flag,
   output logic       err_timeout,
   output logic       bus_enable,
   output logic [1:0] bus_addr,
   output logic       bus_write,
   output logic       bus_read,
   output logic [7:0] bus_wdata,
   input  logic [7:0] bus_rdata,
   input  logic       bus_resp
`ifdef FIFO_INIT_STATS_EN
   ,
   output logic [15:0] wr_count,
   output logic [15:0] rd_count
`endif
);

   localparam int PCW = $clog2(POLL_MAX + 1);
   localparam int LCW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

   state_t           state_reg;
   intent_t          intent_reg;
   logic             drain_pend_reg;
   logic             drain_done_reg;
   logic             err_flag_reg;
   logic             err_timeout_reg;
   logic [PCW-1:0]   poll_cnt_reg;
   logic [LCW-1:0]   lat_cnt_reg;
   logic [7:0]       out_data_reg;

   // The MEM region is never accessed, so its response carries no information.
   logic resp_unused;
   assign resp_unused = bus_resp;

   // -------------------------------------------------------------------------
   // Main FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         intent_reg      <= WR;
         drain_pend_reg  <= 1'b0;
         drain_done_reg  <= 1'b0;
         err_flag_reg    <= 1'b0;
         err_timeout_reg <= 1'b0;
         poll_cnt_reg    <= '0;
         lat_cnt_reg     <= '0;
         out_data_reg    <= 8'h00;
      end else begin
         drain_done_reg <= 1'b0;
         if (drain_req) begin
            drain_pend_reg <= 1'b1;
         end

         case (state_reg)
            IDLE: begin
               // A pending drain wins over a waiting input byte.
               if (drain_pend_reg) begin
                  intent_reg <= RD;
                  state_reg  <= POLL;
               end else if (in_valid) begin
                  intent_reg <= WR;
                  state_reg  <= POLL;
               end
            end

            POLL: begin
               if (bus_rdata[STAT_OVF] || bus_rdata[STAT_UNF]) begin
                  err_flag_reg <= 1'b1;
                  state_reg    <= CLEAR;
               end else if (intent_reg == WR) begin
                  if (bus_rdata[STAT_FULL]) begin
                     // Back off to IDLE and retry; count consecutive full polls.
                     state_reg <= IDLE;
                     if (poll_cnt_reg >= PCW'(POLL_MAX - 1)) begin
                        poll_cnt_reg    <= PCW'(POLL_MAX);
                        err_timeout_reg <= 1'b1;
                     end else begin
                        poll_cnt_reg <= poll_cnt_reg + 1'b1;
                     end
                  end else begin
                     poll_cnt_reg <= '0;
                     state_reg    <= WRITE;
                  end
               end else begin
                  if (bus_rdata[STAT_EMPTY]) begin
                     drain_done_reg <= 1'b1;
                     // A request arriving in this very cycle starts a new drain.
                     drain_pend_reg <= drain_req;
                     state_reg      <= IDLE;
                  end else begin
                     state_reg <= READ;
                  end
               end
            end

            WRITE: begin
               state_reg <= IDLE;
            end

            READ: begin
               if (RD_LAT == 0) begin
                  out_data_reg <= bus_rdata;
                  state_reg    <= OUT;
               end else begin
                  lat_cnt_reg <= LCW'(RD_LAT);
                  state_reg   <= RDW;
               end
            end

            RDW: begin
               lat_cnt_reg <= lat_cnt_reg - 1'b1;
               if (lat_cnt_reg == LCW'(1)) begin
                  out_data_reg <= bus_rdata;
                  state_reg    <= OUT;
               end
            end

            OUT: begin
               if (out_ready) begin
                  intent_reg <= RD;
                  state_reg  <= POLL;
               end
            end

            CLEAR: begin
               state_reg <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Moore output decode from the registered state
   // -------------------------------------------------------------------------
   always_comb begin
      bus_enable = 1'b0;
      bus_addr   = ADDR_FIFO;
      bus_write  = 1'b0;
      bus_read   = 1'b0;
      bus_wdata  = 8'h00;
      in_ready   = 1'b0;
      case (state_reg)
         POLL: begin
            bus_enable = 1'b1;
            bus_addr   = ADDR_STAT;
            bus_read   = 1'b1;
         end
         WRITE: begin
            bus_enable = 1'b1;
            bus_addr   = ADDR_FIFO;
            bus_write  = 1'b1;
            bus_wdata  = in_data;
            in_ready   = 1'b1;
         end
         READ: begin
            bus_enable = 1'b1;
            bus_addr   = ADDR_FIFO;
            bus_read   = 1'b1;
         end
         CLEAR: begin
            bus_enable = 1'b1;
            bus_addr   = ADDR_STAT;
            bus_write  = 1'b1;
            bus_wdata  = CLR_CMD;
         end
         default: begin
         end
      endcase
   end

   assign out_valid   = (state_reg == OUT);
   assign out_data    = out_data_reg;
   assign drain_done  = drain_done_reg;
   assign busy        = (state_reg != IDLE) || drain_pend_reg;
   assign err_flag    = err_flag_reg;
   assign err_timeout = err_timeout_reg;

`ifdef FIFO_INIT_STATS_EN
   // -------------------------------------------------------------------------
   // Transfer statistics
   // -------------------------------------------------------------------------
   logic [15:0] wr_count_reg;
   logic [15:0] rd_count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_count_reg <= 16'h0000;
         rd_count_reg <= 16'h0000;
      end else begin
         if (state_reg == WRITE) begin
            wr_count_reg <= wr_count_reg + 16'h0001;
         end
         if ((state_reg == OUT) && out_ready) begin
            rd_count_reg <= rd_count_reg + 16'h0001;
         end
      end
   end

   assign wr_count = wr_count_reg;
   assign rd_count = rd_count_reg;
`endif

endmodule

// File: tb/tb_fifo_bus_initiator.sv
// -----------------------------------------------------------------------------
// tb_fifo_bus_initiator
// Initiator plus a behavioural FIFO target. Expected data comes from a queue
// model of the target contents; bus activity is logged by a negedge monitor.
// -----------------------------------------------------------------------------
module tb_fifo_bus_initiator;
   import fifo_bus_pkg::*;

   localparam int RD_LAT   = 1;
   localparam int POLL_MAX = 16;
   localparam int DEPTH    = 4;
   localparam int TMO      = 400;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [7:0] in_data, out_data;
   logic       drain_req, drain_done, busy, err_flag, err_timeout;
   logic       bus_enable, bus_write, bus_read;
   logic [1:0] bus_addr;
   logic [7:0] bus_wdata, bus_rdata;
   logic       bus_resp;
`ifdef FIFO_INIT_STATS_EN
   logic [15:0] wr_count, rd_count;
`endif

   always #5 clk = ~clk;

   fifo_bus_initiator #(.RD_LAT(RD_LAT), .POLL_MAX(POLL_MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .drain_req(drain_req), .drain_done(drain_done), .busy(busy),
      .err_flag(err_flag), .err_timeout(err_timeout),
      .bus_enable(bus_enable), .bus_addr(bus_addr), .bus_write(bus_write),
      .bus_read(bus_read), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .bus_resp(bus_resp)
`ifdef FIFO_INIT_STATS_EN
      , .wr_count(wr_count), .rd_count(rd_count)
`endif
   );

   // ---------------- behavioural FIFO target (RD_LAT = 1) ----------------
   logic [7:0] tq[$];
   int         t_cnt = 0;
   logic       t_ovf = 1'b0, t_unf = 1'b0;
   logic [7:0] t_rdq = 8'h00;
   logic       inject_ovf = 1'b0;

   assign bus_resp = 1'b0;

   always_comb begin
      if (bus_enable && bus_read && bus_addr == ADDR_STAT)
         bus_rdata = {4'b0000, t_unf, t_ovf, (t_cnt == DEPTH), (t_cnt == 0)};
      else
         bus_rdata = t_rdq;
   end

   always @(posedge clk) begin
      if (inject_ovf) t_ovf <= 1'b1;
      if (bus_enable && bus_write && bus_addr == ADDR_FIFO) begin
         if (t_cnt == DEPTH) t_ovf <= 1'b1;
         else begin
            tq.push_back(bus_wdata);
            t_cnt <= t_cnt + 1;
         end
      end
      if (bus_enable && bus_write && bus_addr == ADDR_STAT && bus_wdata[STAT_CLR]) begin
         t_ovf <= 1'b0;
         t_unf <= 1'b0;
      end
      if (bus_enable && bus_read && bus_addr == ADDR_FIFO) begin
         if (t_cnt == 0) t_unf <= 1'b1;
         else begin
            t_rdq <= tq.pop_front();
            t_cnt <= t_cnt - 1;
         end
      end
   end

   // ---------------- monitor ----------------
   logic [7:0] wr_log[$];
   logic [7:0] out_log[$];
   int cyc = 0, polls = 0, freads = 0, stat_wr = 0, clr_ok = 0;
   int done_cnt = 0, done_gap = 0, last_poll_cyc = 0;
   int rdy_viol = 0, ob_viol = 0, stab_viol = 0;
   int wr_since_rst = 0, hs_since_rst = 0;
   logic       prev_wait = 1'b0;
   logic [7:0] prev_data = 8'h00;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (!rst_n) begin
         wr_since_rst = 0;
         hs_since_rst = 0;
         prev_wait    = 1'b0;
      end else begin
         if (bus_enable && bus_read && bus_addr == ADDR_STAT) begin
            polls = polls + 1;
            last_poll_cyc = cyc;
         end
         if (bus_enable && bus_read && bus_addr == ADDR_FIFO) freads = freads + 1;
         if (bus_enable && bus_write && bus_addr == ADDR_FIFO) begin
            wr_log.push_back(bus_wdata);
            wr_since_rst = wr_since_rst + 1;
         end
         if (bus_enable && bus_write && bus_addr == ADDR_STAT) begin
            stat_wr = stat_wr + 1;
            if (bus_wdata == CLR_CMD) clr_ok = clr_ok + 1;
         end
         if (in_ready && !(bus_enable && bus_write && bus_addr == ADDR_FIFO)) rdy_viol = rdy_viol + 1;
         if (out_valid && bus_enable) ob_viol = ob_viol + 1;
         if (out_valid && prev_wait && (out_data !== prev_data)) stab_viol = stab_viol + 1;
         prev_wait = out_valid && !out_ready;
         prev_data = out_data;
         if (out_valid && out_ready) begin
            out_log.push_back(out_data);
            hs_since_rst = hs_since_rst + 1;
         end
         if (drain_done) begin
            done_cnt = done_cnt + 1;
            done_gap = cyc - last_poll_cyc;
         end
      end
   end

   // ---------------- checking helpers ----------------
   int tests = 0, fails = 0;
   logic [7:0] exp_q[$];   // model of the target FIFO contents

   logic [26:0] outs_vec;
   assign outs_vec = {in_ready, out_valid, out_data, drain_done, busy, err_flag,
                      err_timeout, bus_enable, bus_addr, bus_write, bus_read, bus_wdata};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the handshake edge.
   task automatic push_one(input logic [7:0] b, input bit hold);
      bit seen = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      for (int n = 0; n < TMO && !seen; n++) begin
         @(negedge clk); #1;
         if (in_ready) seen = 1'b1;
      end
      tests++;
      assert (seen === 1'b1) else begin
         fails++;
         $error("FAIL push_handshake: observed no in_ready expected in_ready for byte 0x%0h", b);
      end
      @(posedge clk); #1;
      if (seen) exp_q.push_back(b);
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic drain_start();
      drain_req = 1'b1;
      @(posedge clk); #1;
      drain_req = 1'b0;
   endtask

   task automatic drain_finish(input string tag, input int d0, input int o0, input bit rnd);
      int n_out;
      for (int n = 0; n < TMO * 8 && done_cnt == d0; n++) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
      check({tag, "_done_gap"}, 32'(done_gap), 32'd1);
      n_out = out_log.size() - o0;
      check({tag, "_count"}, 32'(n_out), 32'(exp_q.size()));
      for (int i = 0; i < n_out && i < exp_q.size(); i++)
         check({tag, "_data"}, 32'(out_log[o0 + i]), 32'(exp_q[i]));
      exp_q.delete();
   endtask

   // ---------------- directed + randomized sequence ----------------
   int p0, r0, w0, d0, o0, c0, s0, k, bound;
   logic [7:0] rb;

   initial begin
      in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1; drain_req = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 32'(outs_vec), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Three bytes with in_valid held: three POLL/WRITE pairs.
      p0 = polls;
      push_one(8'hA5, 1'b1);
      push_one(8'h3C, 1'b1);
      push_one(8'h7E, 1'b0);
      check("wr_count3", 32'(wr_log.size()), 32'd3);
      if (wr_log.size() == 3) begin
         check("wdata0", 32'(wr_log[0]), 32'h A5);
         check("wdata1", 32'(wr_log[1]), 32'h 3C);
         check("wdata2", 32'(wr_log[2]), 32'h 7E);
      end
      check("write_polls", 32'(polls - p0), 32'd3);

      // Drain them back out.
      p0 = polls; r0 = freads; d0 = done_cnt; o0 = out_log.size();
      drain_start();
      drain_finish("drain3", d0, o0, 1'b0);
      check("drain3_polls", 32'(polls - p0), 32'd4);
      check("drain3_reads", 32'(freads - r0), 32'd3);

      // Drain on an empty FIFO: one poll, no data read.
      p0 = polls; r0 = freads; d0 = done_cnt; o0 = out_log.size();
      drain_start();
      drain_finish("drain_empty", d0, o0, 1'b0);
      check("empty_polls", 32'(polls - p0), 32'd1);
      check("empty_reads", 32'(freads - r0), 32'd0);
      check("empty_busy", 32'(busy), 32'd0);

      // Fill to full, then keep offering a byte: full-poll timeout.
      for (int i = 0; i < DEPTH; i++) push_one(8'($urandom), (i < DEPTH - 1));
      w0 = wr_log.size(); p0 = polls;
      in_valid = 1'b1; in_data = 8'hE1;
      for (bound = 0; bound < TMO && (polls - p0) < POLL_MAX - 1; bound++) begin
         @(negedge clk); #1;
      end
      @(negedge clk); #1;
      check("timeout_before", 32'(err_timeout), 32'd0);
      for (bound = 0; bound < TMO && (polls - p0) < POLL_MAX; bound++) begin
         @(negedge clk); #1;
      end
      @(negedge clk); #1;
      check("timeout_after", 32'(err_timeout), 32'd1);
      check("full_no_write", 32'(wr_log.size() - w0), 32'd0);
      @(posedge clk); #1;
      d0 = done_cnt; o0 = out_log.size();
      drain_start();
      drain_finish("drain_full", d0, o0, 1'b0);
      push_one(8'hE1, 1'b0);
      check("write_resumed", 32'(wr_log[wr_log.size() - 1]), 32'h E1);
      check("timeout_sticky", 32'(err_timeout), 32'd1);

      // Randomized rounds: random bytes, random sink backpressure.
      for (int r = 0; r < 4; r++) begin
         k = $urandom_range(1, DEPTH - 1 - exp_q.size());
         for (int i = 0; i < k; i++) begin
            rb = 8'($urandom);
            push_one(rb, (i < k - 1));
         end
         d0 = done_cnt; o0 = out_log.size();
         drain_start();
         drain_finish("rand_drain", d0, o0, 1'b1);
      end

      // Sink stalls for five cycles in OUT.
      push_one(8'h5A, 1'b0);
      d0 = done_cnt; o0 = out_log.size();
      out_ready = 1'b0;
      drain_start();
      for (bound = 0; bound < TMO && !out_valid; bound++) begin
         @(negedge clk); #1;
      end
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_data", 32'(out_data), 32'h 5A);
         check("stall_bus_idle", 32'(bus_enable), 32'd0);
         @(negedge clk); #1;
      end
      @(posedge clk); #1;
      drain_finish("stall_drain", d0, o0, 1'b0);

      // Injected overflow: CLEAR write, sticky err_flag, write retried.
      check("err_flag_clean", 32'(err_flag), 32'd0);
      inject_ovf = 1'b1;
      @(posedge clk); #1;
      inject_ovf = 1'b0;
      c0 = clr_ok; s0 = stat_wr; w0 = wr_log.size();
      push_one(8'hC3, 1'b0);
      check("clear_cmd", 32'(clr_ok - c0), 32'd1);
      check("clear_writes", 32'(stat_wr - s0), 32'd1);
      check("ovf_write_retry", 32'(wr_log.size() - w0), 32'd1);
      check("err_flag_set", 32'(err_flag), 32'd1);
      repeat (8) @(posedge clk);
      #1;
      check("err_flag_sticky", 32'(err_flag), 32'd1);

      // Reset asserted mid-READ: outputs drop at once, FIFO data untouched.
      push_one(8'h96, 1'b0);
      drain_start();
      for (bound = 0; bound < TMO && !(bus_read && bus_addr == ADDR_FIFO); bound++) begin
         @(negedge clk); #1;
      end
      check("in_read_state", 32'(bus_read && bus_addr == ADDR_FIFO), 32'd1);
      rst_n = 1'b0;
      #1;
      check("reset_mid_read", 32'(outs_vec), 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_reset_idle", 32'(busy), 32'd0);
      d0 = done_cnt; o0 = out_log.size();
      drain_start();
      drain_finish("post_reset_drain", d0, o0, 1'b0);

      check("in_ready_outside_write", 32'(rdy_viol), 32'd0);
      check("out_data_stable", 32'(stab_viol), 32'd0);
      check("bus_idle_in_out", 32'(ob_viol), 32'd0);
`ifdef FIFO_INIT_STATS_EN
      check("stat_wr_count", 32'(wr_count), 32'(16'(wr_since_rst)));
      check("stat_rd_count", 32'(rd_count), 32'(16'(hs_since_rst)));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
